// File: rtl/if_fetch_queue_if.sv
// Fetch-side instruction bus: addr_ok/data_ok SRAM-like handshake.
// master = fetch unit, slave = memory side.
interface if_fetch_queue_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_rdata,
    input  inst_data_ok
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_rdata,
    output inst_data_ok
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Sequential-PC fetch unit with an in-order return queue for decode.
// Redirects flush the queue and drop responses still owed by the bus.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int          DEPTH    = 4,
  parameter int          PTR_W    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  if_fetch_queue_if.master    bus,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  input  logic                id_ready,
  output logic [31:0]         IF_IR,
  output logic [31:0]         PC,
  output logic                data_valid
);

  localparam int CNT_W = PTR_W + 1;
  // Back-to-back redirects can stack owed responses past DEPTH.
  localparam int DSC_W = PTR_W + 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic        filled;
  } entry_t;

  entry_t             q [DEPTH];
  logic [31:0]        fetch_pc;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [PTR_W-1:0]   fill_ptr;
  logic [CNT_W-1:0]   alloc_cnt;
  logic [CNT_W-1:0]   pend_cnt;
  logic [DSC_W-1:0]   discard_cnt;
  logic [DSC_W-1:0]   disc_next;

  logic accept;
  logic drop;
  logic fill;
  logic pop;

  assign bus.inst_req  = ~rst & ~redirect
                       & (alloc_cnt < CNT_W'(DEPTH));
  assign bus.inst_addr = fetch_pc;

  assign accept = bus.inst_req & bus.inst_addr_ok;
  assign drop   = bus.inst_data_ok & (discard_cnt != '0);
  assign fill   = bus.inst_data_ok & (discard_cnt == '0)
                & (pend_cnt != '0);

  assign data_valid = q[head].filled & (alloc_cnt != '0);
  assign pop        = data_valid & id_ready;
  assign IF_IR      = q[head].ir;
  assign PC         = q[head].pc;

  // Everything the bus still owes, minus a response landing now.
  assign disc_next = discard_cnt + DSC_W'(pend_cnt)
                   - DSC_W'(drop | fill);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      fill_ptr    <= '0;
      alloc_cnt   <= '0;
      pend_cnt    <= '0;
      discard_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else if (redirect) begin
      fetch_pc    <= redirect_pc;
      head        <= '0;
      tail        <= '0;
      fill_ptr    <= '0;
      alloc_cnt   <= '0;
      pend_cnt    <= '0;
      discard_cnt <= disc_next;
      for (int i = 0; i < DEPTH; i++) q[i].filled <= 1'b0;
    end else begin
      if (accept) begin
        q[tail].pc     <= fetch_pc;
        q[tail].filled <= 1'b0;
        tail           <= tail + PTR_W'(1);
        fetch_pc       <= fetch_pc + 32'd4;
      end
      if (drop) discard_cnt <= discard_cnt - DSC_W'(1);
      if (fill) begin
        q[fill_ptr].ir     <= bus.inst_rdata;
        q[fill_ptr].filled <= 1'b1;
        fill_ptr           <= fill_ptr + PTR_W'(1);
      end
      if (pop) begin
        q[head].filled <= 1'b0;
        head           <= head + PTR_W'(1);
      end
      alloc_cnt <= alloc_cnt + CNT_W'(accept) - CNT_W'(pop);
      pend_cnt  <= pend_cnt + CNT_W'(accept) - CNT_W'(fill);
    end
  end

  a_no_orphan_resp: assert property (
    @(posedge clk) disable iff (rst)
    bus.inst_data_ok |-> (pend_cnt != '0 || discard_cnt != '0)
  );

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: bus model returns ~addr,
// monitor checks every decode pop against expected PCs.
module tb_if_fetch_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic [31:0] IF_IR;
  logic [31:0] PC;
  logic        data_valid;
  logic        resp_en;

  if_fetch_queue_if bus ();

  if_fetch_queue dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_ready    (id_ready),
    .IF_IR       (IF_IR),
    .PC          (PC),
    .data_valid  (data_valid)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          acc_cnt = 0;
  logic [31:0] bq [$];
  logic [31:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pcs(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic drain(input string name, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Memory model: one-cycle response latency, in order.
  initial begin
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = 32'h0;
    forever begin
      @(posedge clk);
      if (rst) bq.delete();
      else if (bus.inst_req && bus.inst_addr_ok) begin
        bq.push_back(bus.inst_addr);
        acc_cnt++;
      end
      #2;
      if (resp_en && !rst && bq.size() > 0) begin
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = ~bq.pop_front();
      end else begin
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'h0;
      end
    end
  end

  // Decode-side monitor.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && !redirect && data_valid && id_ready) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL pop_unexpected: got PC %h expected none", PC);
        end else begin
          e = exp_q.pop_front();
          if (PC !== e || IF_IR !== ~e) begin
            n_err++;
            $display("FAIL pop: got PC %h IR %h expected PC %h IR %h",
                     PC, IF_IR, e, ~e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    id_ready = 1'b0; resp_en = 1'b1; bus.inst_addr_ok = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("rst_req", 32'(bus.inst_req), 32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_pc", PC, 32'h0);
    chk("rst_ir", IF_IR, 32'h0);

    // Streaming fetch, decode always ready.
    tick();
    rst = 1'b0; bus.inst_addr_ok = 1'b1; id_ready = 1'b1;
    push_pcs(32'h1c000000, 8);
    @(negedge clk);
    chk("first_addr", bus.inst_addr, 32'h1c000000);
    chk("first_req", 32'(bus.inst_req), 32'd1);
    base = acc_cnt;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (acc_cnt - base >= 8) break;
    end
    bus.inst_addr_ok = 1'b0;
    drain("stream_drain", 40);

    // Fill to DEPTH with decode stalled, then drain.
    tick();
    id_ready = 1'b0; bus.inst_addr_ok = 1'b1;
    base = acc_cnt;
    repeat (8) tick();
    @(negedge clk);
    chk("full_accepts", 32'(acc_cnt - base), 32'd4);
    chk("full_req", 32'(bus.inst_req), 32'd0);
    push_pcs(32'h1c000020, 4);
    tick();
    id_ready = 1'b1; bus.inst_addr_ok = 1'b0;
    @(negedge clk);
    chk("req_before_pop", 32'(bus.inst_req), 32'd0);
    @(negedge clk);
    chk("req_after_pop", 32'(bus.inst_req), 32'd1);
    drain("full_drain", 20);

    // Redirect with two requests outstanding.
    tick();
    resp_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h1c000010;
    @(negedge clk);
    chk("redir_req", 32'(bus.inst_req), 32'd0);
    tick();
    redirect = 1'b0; bus.inst_addr_ok = 1'b1;
    tick(); tick();
    bus.inst_addr_ok = 1'b0;
    @(negedge clk);
    chk("two_out_addr", bus.inst_addr, 32'h1c000018);
    tick();
    redirect = 1'b1; redirect_pc = 32'h1c000100;
    tick();
    redirect = 1'b0;
    @(negedge clk);
    chk("disc_two", 32'(dut.discard_cnt), 32'd2);
    chk("redir_addr", bus.inst_addr, 32'h1c000100);
    push_pcs(32'h1c000100, 1);
    tick();
    bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok = 1'b0; resp_en = 1'b1;
    drain("redir_drain", 20);

    // Redirect coinciding with a response, three outstanding.
    tick();
    resp_en = 1'b0; bus.inst_addr_ok = 1'b1;
    tick(); tick(); tick();
    bus.inst_addr_ok = 1'b0;
    tick();
    resp_en = 1'b1; redirect = 1'b1; redirect_pc = 32'h1c000200;
    tick();
    redirect = 1'b0; resp_en = 1'b0;
    @(negedge clk);
    chk("disc_resp_same", 32'(dut.discard_cnt), 32'd2);
    chk("disc_valid", 32'(data_valid), 32'd0);
    push_pcs(32'h1c000200, 1);
    tick();
    bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok = 1'b0; resp_en = 1'b1;
    drain("resp_same_drain", 20);

    // Redirect coinciding with a pop.
    tick();
    id_ready = 1'b0; bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("held_valid", 32'(data_valid), 32'd1);
    chk("held_pc", PC, 32'h1c000204);
    tick();
    id_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h1c000300;
    tick();
    redirect = 1'b0; id_ready = 1'b0;
    @(negedge clk);
    chk("pop_redir_valid", 32'(data_valid), 32'd0);
    chk("pop_redir_addr", bus.inst_addr, 32'h1c000300);
    chk("pop_redir_alloc", 32'(dut.alloc_cnt), 32'd0);
    chk("pop_redir_disc", 32'(dut.discard_cnt), 32'd0);

    // Reset with three filled entries.
    tick();
    bus.inst_addr_ok = 1'b1;
    tick(); tick(); tick();
    bus.inst_addr_ok = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("three_alloc", 32'(dut.alloc_cnt), 32'd3);
    chk("three_valid", 32'(data_valid), 32'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_req", 32'(bus.inst_req), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", 32'(data_valid), 32'd0);
    chk("rst_mid_addr", bus.inst_addr, 32'h1c000000);
    chk("rst_mid_disc", 32'(dut.discard_cnt), 32'd0);
    chk("rst_mid_req2", 32'(bus.inst_req), 32'd1);

    tick();
    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
